// File: rtl/seq_error_control.sv
// Sequential pose-error controller: aligns Y, then X, then theta with hysteresis, settle and ramp.
// Optional velocity ramp is built when SEQ_ERROR_CONTROL_RAMP_EN is defined; otherwise commands jump to VEL_MAX.
module seq_error_control #(
  parameter int                 N_WIDTH       = 17,
  parameter logic [N_WIDTH-1:0] H_LIN_ENTER   = 17'h0001A,
  parameter logic [N_WIDTH-1:0] H_LIN_EXIT    = 17'h0000D,
  parameter logic [N_WIDTH-1:0] H_ROT_ENTER   = 17'h00A00,
  parameter logic [N_WIDTH-1:0] H_ROT_EXIT    = 17'h00500,
  parameter logic [N_WIDTH-1:0] VEL_MAX       = 17'h00040,
  parameter logic [N_WIDTH-1:0] RAMP_STEP     = 17'h00010,
  parameter int                 RAMP_DIV      = 4,
  parameter int                 SETTLE_CYCLES = 8
) (
  input  logic               SEQ_ERROR_CONTROL_CLOCK_50,
  input  logic               SEQ_ERROR_CONTROL_RESET_InLow,
  input  logic               SEQ_ERROR_CONTROL_ENABLE_In,
  input  logic [N_WIDTH-1:0] SEQ_ERROR_CONTROL_X_InBus,
  input  logic [N_WIDTH-1:0] SEQ_ERROR_CONTROL_Y_InBus,
  input  logic [N_WIDTH-1:0] SEQ_ERROR_CONTROL_Z_InBus,
  output logic [N_WIDTH-1:0] SEQ_ERROR_CONTROL_VX_OutBus,
  output logic [N_WIDTH-1:0] SEQ_ERROR_CONTROL_VY_OutBus,
  output logic [N_WIDTH-1:0] SEQ_ERROR_CONTROL_WZ_OutBus,
  output logic               SEQ_ERROR_CONTROL_DONE_Out,
  output logic [2:0]         SEQ_ERROR_CONTROL_STATE_OutBus
);
  localparam int MW = N_WIDTH - 1;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  if (RAMP_DIV < 1 || SETTLE_CYCLES < 1 || RAMP_STEP[N_WIDTH-1]) begin : g_param_check
    $error("seq_error_control: RAMP_DIV and SETTLE_CYCLES must be >= 1, RAMP_STEP positive");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ALIGN_Y = 3'd1,
    ALIGN_X = 3'd2,
    ALIGN_Z = 3'd3,
    DONE    = 3'd4
  } state_t;

  logic                clk, rst_n, en;
  logic [N_WIDTH-1:0]  x, y, z;
  assign clk   = SEQ_ERROR_CONTROL_CLOCK_50;
  assign rst_n = SEQ_ERROR_CONTROL_RESET_InLow;
  assign en    = SEQ_ERROR_CONTROL_ENABLE_In;
  assign x     = SEQ_ERROR_CONTROL_X_InBus;
  assign y     = SEQ_ERROR_CONTROL_Y_InBus;
  assign z     = SEQ_ERROR_CONTROL_Z_InBus;

  state_t             state_q, state_d, next_axis;
  logic               moving_q, moving_d;
  logic               dir_q, dir_d;
  logic [MW-1:0]      mag_q, mag_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_WIDTH-1:0] vx_q, vy_q, wz_q, cmd_d;
  logic               done_q;

  // Active-axis error, thresholds and the command sign that error implies (X drives VY inverted).
  logic [N_WIDTH-1:0] err;
  logic [MW-1:0]      enter_th, exit_th;
  logic               err_dir, above_enter, above_exit, any_enter;
  always_comb begin
    err       = '0;
    enter_th  = H_LIN_ENTER[MW-1:0];
    exit_th   = H_LIN_EXIT[MW-1:0];
    next_axis = IDLE;
    case (state_q)
      ALIGN_Y: begin err = y; next_axis = ALIGN_X; end
      ALIGN_X: begin err = x; next_axis = ALIGN_Z; end
      ALIGN_Z: begin
        err       = z;
        enter_th  = H_ROT_ENTER[MW-1:0];
        exit_th   = H_ROT_EXIT[MW-1:0];
        next_axis = DONE;
      end
      default: ;
    endcase
  end
  assign err_dir     = err[N_WIDTH-1] ^ (state_q == ALIGN_X);
  assign above_enter = err[MW-1:0] > enter_th;
  assign above_exit  = err[MW-1:0] > exit_th;
  assign any_enter   = (x[MW-1:0] > H_LIN_ENTER[MW-1:0]) || (y[MW-1:0] > H_LIN_ENTER[MW-1:0]) ||
                       (z[MW-1:0] > H_ROT_ENTER[MW-1:0]);

  logic [MW-1:0] first_mag;
`ifdef SEQ_ERROR_CONTROL_RAMP_EN
  localparam int PW = $clog2(RAMP_DIV + 1);
  logic [PW-1:0] presc_q, presc_d;
  logic [MW:0]   ramp_sum;
  logic [MW-1:0] stepped_mag;
  assign ramp_sum    = {1'b0, mag_q} + {1'b0, RAMP_STEP[MW-1:0]};
  assign first_mag   = (RAMP_STEP[MW-1:0] > VEL_MAX[MW-1:0]) ? VEL_MAX[MW-1:0] : RAMP_STEP[MW-1:0];
  assign stepped_mag = (ramp_sum > {1'b0, VEL_MAX[MW-1:0]}) ? VEL_MAX[MW-1:0] : ramp_sum[MW-1:0];
`else
  assign first_mag = VEL_MAX[MW-1:0];
`endif

  always_comb begin
    state_d  = state_q;
    moving_d = moving_q;
    dir_d    = dir_q;
    mag_d    = mag_q;
    cnt_d    = cnt_q;
`ifdef SEQ_ERROR_CONTROL_RAMP_EN
    presc_d  = presc_q;
`endif
    if (!en || state_q == IDLE) begin
      state_d  = en ? ALIGN_Y : IDLE;
      moving_d = 1'b0;
      dir_d    = 1'b0;
      mag_d    = '0;
      cnt_d    = '0;
`ifdef SEQ_ERROR_CONTROL_RAMP_EN
      presc_d  = '0;
`endif
    end else if (state_q == DONE) begin
      if (any_enter) state_d = ALIGN_Y;
    end else if (!above_exit) begin
      // An in-band sample stops the axis and counts toward settling in the same cycle.
      moving_d = 1'b0;
      dir_d    = 1'b0;
      mag_d    = '0;
`ifdef SEQ_ERROR_CONTROL_RAMP_EN
      presc_d  = '0;
`endif
      if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
        state_d = next_axis;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (moving_q) begin
      cnt_d = '0;
      if (err_dir != dir_q) begin
        dir_d = err_dir;
`ifdef SEQ_ERROR_CONTROL_RAMP_EN
        mag_d   = '0;
        presc_d = '0;
`else
        mag_d = VEL_MAX[MW-1:0];
`endif
      end else begin
`ifdef SEQ_ERROR_CONTROL_RAMP_EN
        // Zero magnitude while moving only follows a reversal; restart the ramp from its first step.
        if (mag_q == '0) begin
          mag_d   = first_mag;
          presc_d = '0;
        end else if (presc_q == PW'(RAMP_DIV - 1)) begin
          mag_d   = stepped_mag;
          presc_d = '0;
        end else begin
          presc_d = presc_q + PW'(1);
        end
`endif
      end
    end else begin
      cnt_d = '0;
      if (above_enter) begin
        moving_d = 1'b1;
        dir_d    = err_dir;
        mag_d    = first_mag;
`ifdef SEQ_ERROR_CONTROL_RAMP_EN
        presc_d  = '0;
`endif
      end
    end
  end

  assign cmd_d = (mag_d == '0) ? '0 : {dir_d, mag_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      moving_q <= 1'b0;
      dir_q    <= 1'b0;
      mag_q    <= '0;
      cnt_q    <= '0;
      vx_q     <= '0;
      vy_q     <= '0;
      wz_q     <= '0;
      done_q   <= 1'b0;
`ifdef SEQ_ERROR_CONTROL_RAMP_EN
      presc_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      moving_q <= moving_d;
      dir_q    <= dir_d;
      mag_q    <= mag_d;
      cnt_q    <= cnt_d;
      vx_q     <= (state_d == ALIGN_Y) ? cmd_d : '0;
      vy_q     <= (state_d == ALIGN_X) ? cmd_d : '0;
      wz_q     <= (state_d == ALIGN_Z) ? cmd_d : '0;
      done_q   <= (state_d == DONE);
`ifdef SEQ_ERROR_CONTROL_RAMP_EN
      presc_q  <= presc_d;
`endif
    end
  end

  assign SEQ_ERROR_CONTROL_VX_OutBus    = vx_q;
  assign SEQ_ERROR_CONTROL_VY_OutBus    = vy_q;
  assign SEQ_ERROR_CONTROL_WZ_OutBus    = wz_q;
  assign SEQ_ERROR_CONTROL_DONE_Out     = done_q;
  assign SEQ_ERROR_CONTROL_STATE_OutBus = state_q;
endmodule

// File: tb/tb_seq_error_control.sv
// Bench for seq_error_control: per-scenario tasks push expected {state,done,vx,vy,wz} and compare on output.
module tb_seq_error_control;
  localparam int W    = 55;
  localparam int STEP = 16'h0010;
  localparam int VMAX = 16'h0040;
  localparam int DIV  = 4;
`ifdef SEQ_ERROR_CONTROL_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, en;
  logic [16:0] x, y, z, vx, vy, wz;
  logic        done;
  logic [2:0]  st;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got, want;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_error_control dut (
    .SEQ_ERROR_CONTROL_CLOCK_50    (clk),
    .SEQ_ERROR_CONTROL_RESET_InLow (rst_n),
    .SEQ_ERROR_CONTROL_ENABLE_In   (en),
    .SEQ_ERROR_CONTROL_X_InBus     (x),
    .SEQ_ERROR_CONTROL_Y_InBus     (y),
    .SEQ_ERROR_CONTROL_Z_InBus     (z),
    .SEQ_ERROR_CONTROL_VX_OutBus   (vx),
    .SEQ_ERROR_CONTROL_VY_OutBus   (vy),
    .SEQ_ERROR_CONTROL_WZ_OutBus   (wz),
    .SEQ_ERROR_CONTROL_DONE_Out    (done),
    .SEQ_ERROR_CONTROL_STATE_OutBus(st)
  );

  function automatic logic [W-1:0] pack(logic [2:0] s, logic d, logic [16:0] a, logic [16:0] b,
                                        logic [16:0] c);
    return {s, d, a, b, c};
  endfunction

  function automatic logic [16:0] cmd(logic neg, logic [15:0] m);
    return (m == 16'd0) ? 17'd0 : {neg, m};
  endfunction

  // Magnitude k cycles after the axis starts moving (k = 1 is the first moving cycle).
  function automatic logic [15:0] ramp_mag(int k);
    int m;
    if (!RAMP) return 16'(VMAX);
    m = STEP * (1 + (k - 1) / DIV);
    if (m > VMAX) m = VMAX;
    return 16'(m);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; x = '0; z = '0; y = 17'h00030;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(pack(3'd0, 1'b0, '0, '0, '0));
      tick();
      got = {st, done, vx, vy, wz}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL reset k=%0d got=%h want=%h", k, got, want); end
    end
    rst_n = 1'b1;
    exp_q.push_back(pack(3'd1, 1'b0, '0, '0, '0));
    tick();
    got = {st, done, vx, vy, wz}; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_err++; $display("FAIL reset_release got=%h want=%h", got, want); end
  endtask

  task automatic test_ramp();
    y = 17'h00030;
    for (int k = 1; k <= 18; k++) begin
      exp_q.push_back(pack(3'd1, 1'b0, cmd(1'b0, ramp_mag(k)), '0, '0));
      tick();
      got = {st, done, vx, vy, wz}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL ramp k=%0d got=%h want=%h", k, got, want); end
    end
  endtask

  task automatic test_hysteresis();
    y = 17'h00014;
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(pack(3'd1, 1'b0, cmd(1'b0, 16'(VMAX)), '0, '0));
      tick();
      got = {st, done, vx, vy, wz}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL hyst_hold k=%0d got=%h want=%h", k, got, want); end
    end
    y = 17'h0000C;
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back(pack((k < 8) ? 3'd1 : 3'd2, 1'b0, '0, '0, '0));
      tick();
      got = {st, done, vx, vy, wz}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL settle_y k=%0d got=%h want=%h", k, got, want); end
    end
  endtask

  task automatic test_flip_x();
    logic [16:0] e;
    x = 17'h00020;
    for (int k = 1; k <= 2; k++) begin
      exp_q.push_back(pack(3'd2, 1'b0, '0, cmd(1'b1, ramp_mag(k)), '0));
      tick();
      got = {st, done, vx, vy, wz}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL x_pos k=%0d got=%h want=%h", k, got, want); end
    end
    x = 17'h10020;
    for (int k = 1; k <= 7; k++) begin
      if (!RAMP) e = cmd(1'b0, 16'(VMAX));
      else e = (k == 1) ? 17'd0 : cmd(1'b0, ramp_mag(k - 1));
      exp_q.push_back(pack(3'd2, 1'b0, '0, e, '0));
      tick();
      got = {st, done, vx, vy, wz}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL x_flip k=%0d got=%h want=%h", k, got, want); end
    end
  endtask

  task automatic test_axis_z_done();
    logic [16:0] e;
    x = '0;
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back(pack((k < 8) ? 3'd2 : 3'd3, 1'b0, '0, '0, '0));
      tick();
      got = {st, done, vx, vy, wz}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL settle_x k=%0d got=%h want=%h", k, got, want); end
    end
    z = 17'h00A00;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(pack(3'd3, 1'b0, '0, '0, '0));
      tick();
      got = {st, done, vx, vy, wz}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL z_at_enter k=%0d got=%h want=%h", k, got, want); end
    end
    z = 17'h00B00;
    for (int k = 1; k <= 2; k++) begin
      exp_q.push_back(pack(3'd3, 1'b0, '0, '0, cmd(1'b0, ramp_mag(k))));
      tick();
      got = {st, done, vx, vy, wz}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL z_pos k=%0d got=%h want=%h", k, got, want); end
    end
    z = 17'h10B00;
    for (int k = 1; k <= 2; k++) begin
      if (!RAMP) e = cmd(1'b1, 16'(VMAX));
      else e = (k == 1) ? 17'd0 : cmd(1'b1, ramp_mag(1));
      exp_q.push_back(pack(3'd3, 1'b0, '0, '0, e));
      tick();
      got = {st, done, vx, vy, wz}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL z_flip k=%0d got=%h want=%h", k, got, want); end
    end
    z = 17'h00500;
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back(pack((k < 8) ? 3'd3 : 3'd4, k == 8, '0, '0, '0));
      tick();
      got = {st, done, vx, vy, wz}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL settle_z k=%0d got=%h want=%h", k, got, want); end
    end
  endtask

  task automatic test_done_restart();
    logic [16:0] ys[4];
    logic [16:0] zs[4];
    ys = '{17'h0001A, 17'h10000, 17'h0000C, 17'h0000C};
    zs = '{17'h00500, 17'h00500, 17'h10A00, 17'h00000};
    for (int k = 0; k < 4; k++) begin
      y = ys[k]; z = zs[k];
      exp_q.push_back(pack(3'd4, 1'b1, '0, '0, '0));
      tick();
      got = {st, done, vx, vy, wz}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL done_hold k=%0d got=%h want=%h", k, got, want); end
    end
    y = 17'h00030;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(pack(3'd1, 1'b0, (k == 1) ? 17'd0 : cmd(1'b0, ramp_mag(k - 1)), '0, '0));
      tick();
      got = {st, done, vx, vy, wz}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL done_restart k=%0d got=%h want=%h", k, got, want); end
    end
  endtask

  task automatic test_enable_drop();
    en = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(pack(3'd0, 1'b0, '0, '0, '0));
      tick();
      got = {st, done, vx, vy, wz}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL enable_low k=%0d got=%h want=%h", k, got, want); end
    end
    en = 1'b1; y = 17'h10030;
    for (int k = 1; k <= 7; k++) begin
      exp_q.push_back(pack(3'd1, 1'b0, (k == 1) ? 17'd0 : cmd(1'b1, ramp_mag(k - 1)), '0, '0));
      tick();
      got = {st, done, vx, vy, wz}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL y_neg k=%0d got=%h want=%h", k, got, want); end
    end
  endtask

  task automatic test_enable_priority();
    y = '0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) en = 1'b0;
      exp_q.push_back(pack((k < 8) ? 3'd1 : 3'd0, 1'b0, '0, '0, '0));
      tick();
      got = {st, done, vx, vy, wz}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL en_priority k=%0d got=%h want=%h", k, got, want); end
    end
    en = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      exp_q.push_back(pack((k < 8) ? 3'd1 : 3'd2, 1'b0, '0, '0, '0));
      tick();
      got = {st, done, vx, vy, wz}; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL resettle k=%0d got=%h want=%h", k, got, want); end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; x = '0; y = '0; z = '0;
    #2;
    test_reset();
    test_ramp();
    test_hysteresis();
    test_flip_x();
    test_axis_z_done();
    test_done_restart();
    test_enable_drop();
    test_enable_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
